gadget_decompose: RTL and testbench

- Sequential signed gadget decomposer for the TFHE key-generation/bootstrapping datapath.
- Inverse direction of the gadget power precompute. That block produces GPow0..GPow2 for recomposition; this block takes one torus coefficient A and emits balanced digits Dig0..Dig2 such that sum Dig_i*2^(DATA_WIDTH-(i+1)*BgLog) ≈ A mod 2^DATA_WIDTH.
- Uses the same start/ready/done handshake as the precompute, so both can share one controller.

---
 rtl/gadget_decompose_pkg.sv | 25 ++
 rtl/gadget_decompose_digit_step.sv | 45 ++++
 rtl/gadget_decompose.sv | 137 +++++++++++++
 tb/tb_gadget_decompose.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/gadget_decompose_pkg.sv
// Shared definitions for the signed gadget decomposer.
//   - default widths / level count
//   - FSM state encoding (IDLE, ROUND, EXTRACT, DONE)
//   - bglog_valid(): a base is usable when BgLog >= 1 and all L digits
//     fit inside the coefficient word (L*BgLog <= DATA_WIDTH).
package gadget_decompose_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N_WIDTH    = 5;
  localparam int DEF_L          = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROUND   = 2'd1,
    ST_EXTRACT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic bglog_valid(input int unsigned bglog,
                                       input int unsigned data_width,
                                       input int unsigned levels);
    return (bglog >= 1) && ((levels * bglog) <= data_width);
  endfunction

endpackage

// File: rtl/gadget_decompose_digit_step.sv
// Combinational single-level digit extraction for the gadget decomposer.
// Ports:
//   acc       : current accumulator; only the low BgLog bits are used
//   carry_in  : carry from the previous (less significant) level
//   bglog     : log2 of the base Bg (runtime)
//   digit     : balanced signed digit in [-2^(BgLog-1), 2^(BgLog-1)-1],
//               sign-extended to DATA_WIDTH
//   carry_out : 1 when the digit was folded into the negative half
module gadget_digit_step #(
  parameter int DATA_WIDTH = 32,
  parameter int n_WIDTH    = 5
) (
  input  logic [DATA_WIDTH-1:0]        acc,
  input  logic                         carry_in,
  input  logic [n_WIDTH-1:0]           bglog,
  output logic signed [DATA_WIDTH-1:0] digit,
  output logic                         carry_out
);

  // One extra bit so that (mask + carry) == 2^BgLog is representable.
  localparam int EW = DATA_WIDTH + 1;

  logic [EW-1:0] full;
  logic [EW-1:0] mask;
  logic [EW-1:0] half;
  logic [EW-1:0] d;
  logic [EW-1:0] folded;

  always_comb begin
    full      = EW'(1) << bglog;
    mask      = full - EW'(1);
    half      = full >> 1;
    d         = ({1'b0, acc} & mask) + EW'(carry_in);
    // Two's-complement wrap of d - 2^BgLog gives the sign-extended negative digit;
    // d == 2^BgLog (carry path only) maps to 0 with carry out.
    folded    = d - full;
    carry_out = 1'b0;
    digit     = $signed(d[DATA_WIDTH-1:0]);
    if (d >= half) begin
      carry_out = 1'b1;
      digit     = $signed(folded[DATA_WIDTH-1:0]);
    end
  end

endmodule

// File: rtl/gadget_decompose.sv
// Sequential signed gadget decomposer.
// Takes a torus coefficient A and base log BgLog, and produces balanced
// digits Dig0 (MSB level) .. Dig2 (LSB level) such that
//   sum Dig_i * 2^(DATA_WIDTH-(i+1)*BgLog) ~= A  mod 2^DATA_WIDTH.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-low reset
//   start      : request, sampled only while ready
//   A, BgLog   : operands, latched with start
//   Dig0..Dig2 : signed digits, held until overwritten by the next request
//   ready      : high in IDLE
//   done       : one-cycle completion pulse
//   err        : last request had an unusable BgLog (digits forced to 0)
module gadget_decompose
  import gadget_decompose_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int n_WIDTH    = DEF_N_WIDTH,
  parameter int L          = DEF_L
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_WIDTH-1:0]        A,
  input  logic [n_WIDTH-1:0]           BgLog,
  output logic signed [DATA_WIDTH-1:0] Dig0,
  output logic signed [DATA_WIDTH-1:0] Dig1,
  output logic signed [DATA_WIDTH-1:0] Dig2,
  output logic                         ready,
  output logic                         done,
  output logic                         err
);

  localparam int LVL_W = (L > 1) ? $clog2(L) : 1;

  state_t                         state_q, state_d;
  logic [DATA_WIDTH-1:0]          a_q;
  logic [n_WIDTH-1:0]             bglog_q;
  logic [DATA_WIDTH-1:0]          acc_q;
  logic                           carry_q;
  logic [LVL_W-1:0]               level_q;
  logic                           start_valid;
  logic [31:0]                    shift_amt;
  logic signed [DATA_WIDTH-1:0]   step_digit;
  logic                           step_carry;

  // Round-to-nearest then drop the bits below the last digit level.
  // The add wraps modulo 2^DATA_WIDTH, which is the intended torus wrap.
  function automatic logic [DATA_WIDTH-1:0] round_shift(input logic [DATA_WIDTH-1:0] a,
                                                        input logic [31:0]           sh);
    logic [DATA_WIDTH-1:0] half;
    half = '0;
    if (sh == 32'd0) return a;
    half = DATA_WIDTH'(1) << (sh - 32'd1);
    return (a + half) >> sh;
  endfunction

  assign start_valid = bglog_valid(32'(BgLog), DATA_WIDTH, L);
  assign shift_amt   = 32'(DATA_WIDTH) - 32'(L) * 32'(bglog_q);
  assign ready       = (state_q == ST_IDLE);
  assign done        = (state_q == ST_DONE);

  gadget_digit_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .n_WIDTH    (n_WIDTH)
  ) u_step (
    .acc       (acc_q),
    .carry_in  (carry_q),
    .bglog     (bglog_q),
    .digit     (step_digit),
    .carry_out (step_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = start_valid ? ST_ROUND : ST_DONE;
      ST_ROUND:   state_d = ST_EXTRACT;
      ST_EXTRACT: if (level_q == '0) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      bglog_q <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      level_q <= '0;
      Dig0    <= '0;
      Dig1    <= '0;
      Dig2    <= '0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        // capture request; a bad base completes immediately with zero digits
        ST_IDLE: begin
          if (start) begin
            a_q     <= A;
            bglog_q <= BgLog;
            if (start_valid) begin
              err <= 1'b0;
            end else begin
              err  <= 1'b1;
              Dig0 <= '0;
              Dig1 <= '0;
              Dig2 <= '0;
            end
          end
        end
        // round into the digit window
        ST_ROUND: begin
          acc_q   <= round_shift(a_q, shift_amt);
          carry_q <= 1'b0;
          level_q <= LVL_W'(L - 1);
        end
        // one digit per cycle, least significant level first
        ST_EXTRACT: begin
          if (level_q == '0)                Dig0 <= step_digit;
          else if (level_q == LVL_W'(1))    Dig1 <= step_digit;
          else                              Dig2 <= step_digit;
          acc_q   <= acc_q >> bglog_q;
          carry_q <= step_carry;
          level_q <= level_q - LVL_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gadget_decompose.sv
module tb_gadget_decompose;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [31:0]        A = '0;
  logic [4:0]         BgLog = '0;
  logic signed [31:0] Dig0, Dig1, Dig2;
  logic               ready, done, err;

  int errors = 0;
  int checks = 0;

  gadget_decompose dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .BgLog (BgLog),
    .Dig0  (Dig0),
    .Dig1  (Dig1),
    .Dig2  (Dig2),
    .ready (ready),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request on the next edge; returns #1 after that edge (edge k).
  task automatic issue(input logic [31:0] a, input logic [4:0] b);
    @(negedge clk);
    start = 1'b1;
    A     = a;
    BgLog = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Valid request: done must be low after edges k+1..k+3 and high after k+4.
  task automatic run_valid(input string tag, input logic [31:0] a, input logic [4:0] b,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic early;
    issue(a, b);
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      if (done) early = 1'b1;
    end
    check({tag, ".early_done"}, 32'(early), 32'd0);
    edge_step();
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".err"},  32'(err),  32'd0);
    check({tag, ".dig0"}, Dig0, e0);
    check({tag, ".dig1"}, Dig1, e1);
    check({tag, ".dig2"}, Dig2, e2);
    edge_step();
    check({tag, ".ready_back"}, 32'(ready), 32'd1);
    check({tag, ".done_low"},   32'(done),  32'd0);
  endtask

  task automatic run_invalid(input string tag, input logic [31:0] a, input logic [4:0] b);
    issue(a, b);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".err"},  32'(err),  32'd1);
    check({tag, ".dig0"}, Dig0, 32'd0);
    check({tag, ".dig1"}, Dig1, 32'd0);
    check({tag, ".dig2"}, Dig2, 32'd0);
    edge_step();
    check({tag, ".ready_back"}, 32'(ready), 32'd1);
    check({tag, ".err_hold"},   32'(err),   32'd1);
  endtask

  initial begin : stim
    logic seen;
    // reset state
    #1;
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.done",  32'(done),  32'd0);
    check("rst.err",   32'(err),   32'd0);
    check("rst.dig0",  Dig0, 32'd0);
    check("rst.dig2",  Dig2, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // main function
    run_valid("b8_12345678", 32'h12345678, 5'd8, 32'd18, 32'd52, 32'd86);
    run_valid("b8_80808080", 32'h80808080, 5'd8, -32'sd127, -32'sd127, -32'sd127);
    run_valid("b8_00008000", 32'h00008000, 5'd8, 32'd0, 32'd1, -32'sd128);
    run_valid("b8_ffffffff", 32'hFFFFFFFF, 5'd8, 32'd0, 32'd0, 32'd0);
    run_valid("b10_12345678", 32'h12345678, 5'd10, 32'd73, -32'sd187, 32'd414);

    // invalid bases, then a valid start clears err
    run_invalid("b11", 32'h12345678, 5'd11);
    run_invalid("b0",  32'h12345678, 5'd0);
    run_valid("b8_after_err", 32'h12345678, 5'd8, 32'd18, 32'd52, 32'd86);

    // start pulses while busy are ignored (an invalid base would set err)
    issue(32'h12345678, 5'd10);
    @(negedge clk);
    start = 1'b1;
    A     = 32'hDEADBEEF;
    BgLog = 5'd0;
    repeat (3) @(posedge clk);   // edges k+1..k+3
    @(posedge clk);              // edge k+4 -> DONE
    #1;
    check("busy.done", 32'(done), 32'd1);
    check("busy.err",  32'(err),  32'd0);
    check("busy.dig0", Dig0, 32'd73);
    check("busy.dig1", Dig1, -32'sd187);
    check("busy.dig2", Dig2, 32'd414);
    // start still held: DONE edge does not accept, first IDLE edge does
    @(negedge clk);
    A     = 32'h80808080;
    BgLog = 5'd8;
    edge_step();
    check("held.ready_idle", 32'(ready), 32'd1);
    edge_step();
    check("held.accepted", 32'(ready), 32'd0);
    start = 1'b0;
    repeat (3) edge_step();
    edge_step();
    check("held.done", 32'(done), 32'd1);
    check("held.dig1", Dig1, -32'sd127);
    edge_step();

    // asynchronous reset during EXTRACT aborts with no done pulse
    issue(32'h12345678, 5'd8);
    edge_step();                 // ROUND executed
    edge_step();                 // first digit written
    check("abort.pre_dig2", Dig2, 32'd86);
    rst = 1'b0;
    #1;
    check("abort.ready", 32'(ready), 32'd1);
    check("abort.dig2",  Dig2, 32'd0);
    check("abort.done",  32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      edge_step();
      if (done) seen = 1'b1;
    end
    check("abort.no_done", 32'(seen), 32'd0);
    check("abort.dig0",    Dig0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
